tmds_encoder: RTL
=================

TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 The block SHALL have no parameters: widths are fixed at 8-bit pixel in and 10-bit symbol out.
REQ-002 i_pixclk  input  1  pixel clock, the single clock; all state SHALL update on its rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-low; sampled only on the rising edge of i_pixclk.
REQ-004 i_data  input  8  pixel component for this channel, valid when i_de=1.
REQ-005 i_de  input  1  data enable: 1 = active video, 0 = blanking.
REQ-006 i_c0  input  1  control bit 0, used when i_de=0 (HSYNC on blue channel).
REQ-007 i_c1  input  1  control bit 1, used when i_de=0 (VSYNC on blue channel).
REQ-008 o_encode  output  10  registered TMDS symbol, bit 0 transmitted first, feeds the 10:1 serializer's parallel input.

Function
REQ-009 Pipeline depth SHALL be fixed at 2: inputs sampled at edge k SHALL appear on o_encode after edge k+2, every cycle, with no stalls.
REQ-010 Stage 1 SHALL register i_de, i_c1, i_c0 and the 9-bit transition-minimised word q_m.
REQ-011 Stage 1 q_m SHALL be built as follows: n1d = ones(i_data); q_m[0] = i_data[0].
REQ-012 Stage 1 XNOR mode: if n1d>4, or n1d==4 with i_data[0]==0, then q_m[i] = q_m[i-1] XNOR i_data[i] for i=1..7, and q_m[8]=0.
REQ-013 Stage 1 XOR mode: otherwise q_m[i] = q_m[i-1] XOR i_data[i] for i=1..7, and q_m[8]=1.
REQ-014 Stage 2 SHALL hold a signed 5-bit running disparity cnt, range -16..+15.
REQ-015 Stage 2 SHALL compute n1q and n0q over q_m[7:0] only.
REQ-016 Stage 2, de=1, case A (cnt==0 or n1q==n0q): out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
REQ-017 Case A disparity update: cnt += (q_m[8] ? n1q-n0q : n0q-n1q).
REQ-018 Stage 2, de=1, case B ((cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q)): out = {1, q_m[8], ~q_m[7:0]}.
REQ-019 Case B disparity update: cnt += 2*q_m[8] + n0q - n1q.
REQ-020 Stage 2, de=1, case C (neither A nor B): out = {0, q_m[8], q_m[7:0]}.
REQ-021 Case C disparity update: cnt += n1q - n0q - 2*(~q_m[8]).
REQ-022 Stage 2, de=0, control tokens: {c1,c0} 00->10'h354, 01->10'h0AB, 10->10'h154, 11->10'h2AB.
REQ-023 When stage-2 de=0, cnt SHALL be forced to 0 on the same edge.
REQ-024 All disparity arithmetic SHALL be sign-extended 5-bit two's complement, with no saturation; a valid stream never leaves -10..+10.
REQ-025 de transitions SHALL take effect per symbol with no extra latency: the first active symbol after blanking SHALL start from cnt=0.
REQ-026 All outputs SHALL be driven from registers, with no combinational path from inputs to o_encode.

Reset
REQ-027 While i_reset=0 at an edge: o_encode=10'h354, cnt=0, stage-1 de=0, c1=c0=0, q_m=0.
REQ-028 Reset asserted mid-frame SHALL take effect at the next edge, discarding both pipeline stages.
REQ-029 After reset release at edge r, o_encode SHALL be 10'h354 until edge r+2, then SHALL follow the inputs sampled from edge r onward.

Verification
REQ-030 Reset: hold i_reset=0 for 3 cycles with random inputs -> o_encode=10'h354 on every cycle; internal cnt=0.
REQ-031 Control tokens: de=0, {c1,c0} stepped 00,01,10,11 -> o_encode 354,0AB,154,2AB, each 2 cycles after its input.
REQ-032 Zero run: de=1, i_data=8'h00 for 3 symbols from cnt=0 -> o_encode 100,3FF,100; cnt -8,+2,-6.
REQ-033 Ones: de=1, i_data=8'hFF from cnt=0 -> o_encode=10'h200; cnt=-8.
REQ-034 Blanking reset of disparity: de=1 with 8'h00 (cnt=-8), then de=0 for 1 symbol, then de=1 with 8'h00 -> last symbol=10'h100; cnt is 0 before it.
REQ-035 Random: 10^5 random de/data/control cycles checked against a bit-accurate DVI 1.0 encoder model; additionally, decoding o_encode SHALL reproduce i_data, and |cnt| SHALL stay <=10.

Source files
------------

// File: rtl/tmds_encoder_if.sv
// Pixel-side bundle of one TMDS channel: pixel/control inputs and the 10-bit symbol out.
interface tmds_encoder_if;
    logic [7:0] i_data;
    logic       i_de;
    logic       i_c0;
    logic       i_c1;
    logic [9:0] o_encode;

    modport master (
        output i_data, i_de, i_c0, i_c1,
        input  o_encode
    );

    modport slave (
        input  i_data, i_de, i_c0, i_c1,
        output o_encode
    );
endinterface

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b channel encoder: two-stage pipeline, transition
// minimisation in stage 1, DC balancing with a running disparity in stage 2.
module tmds_encoder (
    input  logic           i_pixclk,
    input  logic           i_reset,
    tmds_encoder_if.slave  bus
);

    localparam logic [9:0] TOKEN_00 = 10'h354;
    localparam logic [9:0] TOKEN_01 = 10'h0AB;
    localparam logic [9:0] TOKEN_10 = 10'h154;
    localparam logic [9:0] TOKEN_11 = 10'h2AB;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int unsigned i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Stage 1 registers
    logic [8:0] q_m;
    logic       de_s1;
    logic       c0_s1;
    logic       c1_s1;

    // Stage 2 registers
    logic signed [4:0] cnt;
    logic [9:0]        encode;

    // Stage 2 combinational results
    logic [3:0]        n1q;
    logic [3:0]        n0q;
    logic signed [4:0] bal;
    logic signed [4:0] cnt_next;
    logic [9:0]        encode_next;

    always_ff @(posedge i_pixclk) begin
        if (!i_reset) begin
            q_m   <= '0;
            de_s1 <= 1'b0;
            c0_s1 <= 1'b0;
            c1_s1 <= 1'b0;
        end else begin
            q_m   <= minimise(bus.i_data);
            de_s1 <= bus.i_de;
            c0_s1 <= bus.i_c0;
            c1_s1 <= bus.i_c1;
        end
    end

    always_comb begin
        n1q         = ones8(q_m[7:0]);
        n0q         = 4'd8 - n1q;
        bal         = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
        cnt_next    = '0;
        encode_next = TOKEN_00;
        if (!de_s1) begin
            unique case ({c1_s1, c0_s1})
                2'b00:   encode_next = TOKEN_00;
                2'b01:   encode_next = TOKEN_01;
                2'b10:   encode_next = TOKEN_10;
                default: encode_next = TOKEN_11;
            endcase
        end else if ((cnt == 5'sd0) || (bal == 5'sd0)) begin
            encode_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_next    = q_m[8] ? (cnt + bal) : (cnt - bal);
        end else if (((cnt > 5'sd0) && (bal > 5'sd0)) ||
                     ((cnt < 5'sd0) && (bal < 5'sd0))) begin
            encode_next = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_next    = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - bal;
        end else begin
            encode_next = {1'b0, q_m[8], q_m[7:0]};
            cnt_next    = cnt + bal - (q_m[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (!i_reset) begin
            cnt    <= '0;
            encode <= TOKEN_00;
        end else begin
            cnt    <= cnt_next;
            encode <= encode_next;
        end
    end

    assign bus.o_encode = encode;

endmodule
